// File: rtl/uart_rx_pkt_ctrl.sv
// rtl/uart_rx_pkt_ctrl.sv - sync-hunting, length-prefixed, checksummed packet parser behind a UART receiver
module uart_rx_pkt_ctrl #(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_char,
    input  logic       rx_valid,
    input  logic       rx_frame_error,
    input  logic       rx_parity_error,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic       pkt_last,
    output logic       err_valid,
    output logic [2:0] err_code,
    output logic       busy
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ERR_LINE    = 3'd1;
    localparam logic [2:0] ERR_BADLEN  = 3'd2;
    localparam logic [2:0] ERR_CHKSUM  = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_OVERRUN = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DRAIN
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [LW-1:0] len;
    logic [LW-1:0] idx;
    logic [7:0]    sum;
    logic [CW-1:0] idle_cnt;
    logic [7:0]    pkt_buf [0:MAX_LEN-1];

    logic          good;
    logic          bad_line;
    logic          timed_out;
    logic          len_ok;
    logic          chk_ok;
    logic          last_idx;
    logic          xfer;
    logic          err_set;
    logic [2:0]    err_nx;
    logic [AW-1:0] buf_addr;

    assign good      = rx_valid & ~rx_frame_error & ~rx_parity_error;
    assign bad_line  = rx_valid & (rx_frame_error | rx_parity_error);
    // A byte landing in the timeout cycle takes priority over the timeout.
    assign timed_out = ~rx_valid && (idle_cnt == TO_LAST);
    assign len_ok    = (rx_char != 8'd0) && (rx_char <= MAX_LEN_B);
    assign chk_ok    = rx_char == (8'(len) + sum);
    // Shared by PAYLOAD (final byte written) and DRAIN (next presented byte is final).
    assign last_idx  = idx == (len - LW'(1));
    assign xfer      = pkt_valid & pkt_ready;
    assign buf_addr  = idx[AW-1:0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and rejection decode.
    always_comb begin
        state_nx = state;
        err_set  = 1'b0;
        err_nx   = 3'd0;
        case (state)
            S_IDLE: begin
                if (good && rx_char == SYNC_BYTE) state_nx = S_LEN;
            end
            S_LEN, S_PAYLOAD, S_CHK: begin
                if (bad_line) begin
                    err_set  = 1'b1;
                    err_nx   = ERR_LINE;
                    state_nx = S_IDLE;
                end else if (timed_out) begin
                    err_set  = 1'b1;
                    err_nx   = ERR_TIMEOUT;
                    state_nx = S_IDLE;
                end else if (good) begin
                    if (state == S_LEN) begin
                        if (len_ok) begin
                            state_nx = S_PAYLOAD;
                        end else begin
                            err_set  = 1'b1;
                            err_nx   = ERR_BADLEN;
                            state_nx = S_IDLE;
                        end
                    end else if (state == S_PAYLOAD) begin
                        if (last_idx) state_nx = S_CHK;
                    end else begin
                        if (chk_ok) begin
                            state_nx = S_DRAIN;
                        end else begin
                            err_set  = 1'b1;
                            err_nx   = ERR_CHKSUM;
                            state_nx = S_IDLE;
                        end
                    end
                end
            end
            S_DRAIN: begin
                // Bytes arriving while the buffer drains are dropped and reported.
                if (rx_valid) begin
                    err_set = 1'b1;
                    err_nx  = ERR_OVERRUN;
                end
                if (xfer && pkt_last) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Status outputs derived from the current state.
    always_comb begin
        busy = (state != S_IDLE);
    end

    // Counters, checksum, error reporting and the output stream registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len       <= '0;
            idx       <= '0;
            sum       <= 8'd0;
            idle_cnt  <= '0;
            pkt_data  <= 8'd0;
            pkt_valid <= 1'b0;
            pkt_last  <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= 3'd0;
        end else begin
            err_valid <= err_set;
            if (err_set) err_code <= err_nx;

            if (rx_valid || state == S_IDLE || state == S_DRAIN) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + CW'(1);
            end

            case (state)
                S_LEN: begin
                    if (good && len_ok) begin
                        len <= LW'(rx_char);
                        idx <= '0;
                        sum <= 8'd0;
                    end
                end
                S_PAYLOAD: begin
                    if (good) begin
                        sum <= sum + rx_char;
                        idx <= idx + LW'(1);
                    end
                end
                S_CHK: begin
                    if (good && chk_ok) begin
                        pkt_valid <= 1'b1;
                        pkt_data  <= pkt_buf[0];
                        pkt_last  <= (len == LW'(1));
                        idx       <= LW'(1);
                    end
                end
                S_DRAIN: begin
                    if (xfer) begin
                        if (pkt_last) begin
                            pkt_valid <= 1'b0;
                            pkt_last  <= 1'b0;
                        end else begin
                            pkt_data <= pkt_buf[buf_addr];
                            pkt_last <= last_idx;
                            idx      <= idx + LW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload buffer write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && good) pkt_buf[buf_addr] <= rx_char;
    end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// tb/tb_uart_rx_pkt_ctrl.sv - table-driven and directed bench for uart_rx_pkt_ctrl
module tb_uart_rx_pkt_ctrl;

    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_char = 8'd0;
    logic       rx_valid = 1'b0;
    logic       rx_frame_error = 1'b0;
    logic       rx_parity_error = 1'b0;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_ready = 1'b1;
    logic       pkt_last;
    logic       err_valid;
    logic [2:0] err_code;
    logic       busy;

    int total = 0;
    int bad   = 0;

    uart_rx_pkt_ctrl #(
        .MAX_LEN        (16),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_char         (rx_char),
        .rx_valid        (rx_valid),
        .rx_frame_error  (rx_frame_error),
        .rx_parity_error (rx_parity_error),
        .pkt_data        (pkt_data),
        .pkt_valid       (pkt_valid),
        .pkt_ready       (pkt_ready),
        .pkt_last        (pkt_last),
        .err_valid       (err_valid),
        .err_code        (err_code),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] ch;
        logic       fe;
        logic       pe;
        logic       rdy;
        logic       e_pv;
        logic [7:0] e_pd;
        logic       e_pl;
        logic       e_ev;
        logic [2:0] e_ec;
        logic       e_busy;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic v, input logic [7:0] ch, input logic fe, input logic pe,
                       input logic rdy, input logic pv, input logic [7:0] pd, input logic pl,
                       input logic ev, input logic [2:0] ec, input logic bsy);
        vec_t r;
        r.v = v; r.ch = ch; r.fe = fe; r.pe = pe; r.rdy = rdy;
        r.e_pv = pv; r.e_pd = pd; r.e_pl = pl; r.e_ev = ev; r.e_ec = ec; r.e_busy = bsy;
        vt.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // pkt_data only matters while pkt_valid is high.
    function automatic logic [14:0] outs();
        return {pkt_valid, (pkt_valid ? pkt_data : 8'h00), pkt_last, err_valid, err_code, busy};
    endfunction

    function automatic logic [14:0] expo(input logic pv, input logic [7:0] pd, input logic pl,
                                         input logic ev, input logic [2:0] ec, input logic bsy);
        return {pv, (pv ? pd : 8'h00), pl, ev, ec, bsy};
    endfunction

    task automatic send(input logic [7:0] ch, input logic fe, input logic pe);
        rx_char = ch; rx_frame_error = fe; rx_parity_error = pe; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_frame_error = 1'b0; rx_parity_error = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin : main
        logic [7:0] exp_d [3];
        logic [7:0] prev_d;
        logic       prev_l;
        logic       prev_stall;
        int         got;

        // Good packet, ready held high.
        add(1,8'hA5,0,0,1, 0,8'h00,0,0,3'd0,1);
        add(1,8'h03,0,0,1, 0,8'h00,0,0,3'd0,1);
        add(1,8'h11,0,0,1, 0,8'h00,0,0,3'd0,1);
        add(1,8'h22,0,0,1, 0,8'h00,0,0,3'd0,1);
        add(1,8'h33,0,0,1, 0,8'h00,0,0,3'd0,1);
        add(1,8'h69,0,0,1, 1,8'h11,0,0,3'd0,1);
        add(0,8'h00,0,0,1, 1,8'h22,0,0,3'd0,1);
        add(0,8'h00,0,0,1, 1,8'h33,1,0,3'd0,1);
        add(0,8'h00,0,0,1, 0,8'h00,0,0,3'd0,0);
        // IDLE ignores non-sync and errored sync bytes.
        add(1,8'h55,0,0,1, 0,8'h00,0,0,3'd0,0);
        add(1,8'hA5,0,1,1, 0,8'h00,0,0,3'd0,0);
        add(1,8'hA5,1,0,1, 0,8'h00,0,0,3'd0,0);
        // LEN 0 and LEN 17 rejected.
        add(1,8'hA5,0,0,1, 0,8'h00,0,0,3'd0,1);
        add(1,8'h00,0,0,1, 0,8'h00,0,1,3'd2,0);
        add(0,8'h00,0,0,1, 0,8'h00,0,0,3'd2,0);
        add(1,8'hA5,0,0,1, 0,8'h00,0,0,3'd2,1);
        add(1,8'h11,0,0,1, 0,8'h00,0,1,3'd2,0);
        // LEN 1 packet.
        add(1,8'hA5,0,0,1, 0,8'h00,0,0,3'd2,1);
        add(1,8'h01,0,0,1, 0,8'h00,0,0,3'd2,1);
        add(1,8'h7E,0,0,1, 0,8'h00,0,0,3'd2,1);
        add(1,8'h7F,0,0,1, 1,8'h7E,1,0,3'd2,1);
        add(0,8'h00,0,0,1, 0,8'h00,0,0,3'd2,0);
        // LEN 16 accepted, then parity error in payload.
        add(1,8'hA5,0,0,1, 0,8'h00,0,0,3'd2,1);
        add(1,8'h10,0,0,1, 0,8'h00,0,0,3'd2,1);
        add(1,8'h10,0,0,1, 0,8'h00,0,0,3'd2,1);
        add(1,8'h20,0,1,1, 0,8'h00,0,1,3'd1,0);
        // Bad checksum, then the corrected packet with one stall.
        add(1,8'hA5,0,0,1, 0,8'h00,0,0,3'd1,1);
        add(1,8'h02,0,0,1, 0,8'h00,0,0,3'd1,1);
        add(1,8'h10,0,0,1, 0,8'h00,0,0,3'd1,1);
        add(1,8'h20,0,0,1, 0,8'h00,0,0,3'd1,1);
        add(1,8'h31,0,0,1, 0,8'h00,0,1,3'd3,0);
        add(1,8'hA5,0,0,1, 0,8'h00,0,0,3'd3,1);
        add(1,8'h02,0,0,1, 0,8'h00,0,0,3'd3,1);
        add(1,8'h10,0,0,1, 0,8'h00,0,0,3'd3,1);
        add(1,8'h20,0,0,1, 0,8'h00,0,0,3'd3,1);
        add(1,8'h32,0,0,1, 1,8'h10,0,0,3'd3,1);
        add(0,8'h00,0,0,0, 1,8'h10,0,0,3'd3,1);
        add(0,8'h00,0,0,1, 1,8'h20,1,0,3'd3,1);
        add(0,8'h00,0,0,1, 0,8'h00,0,0,3'd3,0);
        // Framed-error A5 in CHK is a line error and is not taken as a new sync.
        add(1,8'hA5,0,0,1, 0,8'h00,0,0,3'd3,1);
        add(1,8'h01,0,0,1, 0,8'h00,0,0,3'd3,1);
        add(1,8'h44,0,0,1, 0,8'h00,0,0,3'd3,1);
        add(1,8'hA5,1,0,1, 0,8'h00,0,1,3'd1,0);
        add(1,8'h01,0,0,1, 0,8'h00,0,0,3'd1,0);
        // Parity error on the LEN byte.
        add(1,8'hA5,0,0,1, 0,8'h00,0,0,3'd1,1);
        add(1,8'h05,0,1,1, 0,8'h00,0,1,3'd1,0);

        // Reset state.
        idle(3);
        chk("reset_outs", {pkt_valid, pkt_data, pkt_last, err_valid, err_code, busy}, 32'd0);
        rst = 1'b0;
        idle(1);
        chk("post_reset_outs", {pkt_valid, pkt_data, pkt_last, err_valid, err_code, busy}, 32'd0);

        for (int i = 0; i < vt.size(); i++) begin
            rx_char = vt[i].ch; rx_frame_error = vt[i].fe; rx_parity_error = vt[i].pe;
            rx_valid = vt[i].v; pkt_ready = vt[i].rdy;
            @(posedge clk); #1;
            rx_valid = 1'b0; rx_frame_error = 1'b0; rx_parity_error = 1'b0;
            chk($sformatf("vec%0d", i), outs(),
                expo(vt[i].e_pv, vt[i].e_pd, vt[i].e_pl, vt[i].e_ev, vt[i].e_ec, vt[i].e_busy));
        end

        // Toggling ready with an overrun byte mid-drain.
        pkt_ready = 1'b1;
        send(8'hA5,0,0); send(8'h03,0,0); send(8'h11,0,0); send(8'h22,0,0); send(8'h33,0,0);
        send(8'h69,0,0);
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        got = 0; prev_stall = 1'b0; prev_d = 8'h00; prev_l = 1'b0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            pkt_ready = (c % 2 == 1);
            rx_char   = 8'h5A;
            rx_valid  = (c == 2);
            if (prev_stall) chk($sformatf("stall_hold%0d", c), {pkt_valid, pkt_data, pkt_last}, {1'b1, prev_d, prev_l});
            if (pkt_valid && pkt_ready) begin
                chk($sformatf("stream_byte%0d", got), {pkt_data, pkt_last}, {exp_d[got], (got == 2)});
                got++;
            end
            prev_stall = pkt_valid && !pkt_ready;
            prev_d = pkt_data; prev_l = pkt_last;
            @(posedge clk); #1;
            rx_valid = 1'b0;
            if (c == 2) chk("overrun_err", {err_valid, err_code}, {1'b1, 3'd5});
        end
        chk("stream_count", got, 3);
        chk("stream_end", outs(), expo(0, 8'h00, 0, 0, 3'd5, 0));

        // Silence for TIMEOUT_CYCLES inside a packet.
        pkt_ready = 1'b1;
        send(8'hA5,0,0); send(8'h02,0,0); send(8'h10,0,0);
        idle(TO - 1);
        chk("timeout_pre", {err_valid, busy}, 2'b01);
        idle(1);
        chk("timeout_fire", {err_valid, err_code, busy}, {1'b1, 3'd4, 1'b0});
        // A byte in the timeout cycle wins.
        send(8'hA5,0,0); send(8'h02,0,0); send(8'h10,0,0);
        idle(TO - 1);
        send(8'h20,0,0);
        chk("timeout_edge_accept", {err_valid, err_code, busy}, {1'b0, 3'd4, 1'b1});
        send(8'h32,0,0);
        chk("timeout_edge_pkt0", outs(), expo(1, 8'h10, 0, 0, 3'd4, 1));
        idle(1);
        chk("timeout_edge_pkt1", outs(), expo(1, 8'h20, 1, 0, 3'd4, 1));
        idle(1);
        chk("timeout_edge_done", outs(), expo(0, 8'h00, 0, 0, 3'd4, 0));

        // Asynchronous reset mid-payload.
        send(8'hA5,0,0); send(8'h03,0,0); send(8'h11,0,0);
        rst = 1'b1;
        #2;
        chk("async_reset", {pkt_valid, pkt_data, pkt_last, err_valid, err_code, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(8'hA5,0,0); send(8'h01,0,0); send(8'h7E,0,0); send(8'h7F,0,0);
        chk("after_reset_pkt", outs(), expo(1, 8'h7E, 1, 0, 3'd0, 1));
        idle(1);
        chk("after_reset_done", outs(), expo(0, 8'h00, 0, 0, 3'd0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
